uart_rx_fifo: RTL and testbench
===============================

# uart_rx_fifo

Receive-side byte buffer placed directly downstream of the UART receiver. It captures each byte the receiver completes, stores it in a first-in-first-out queue, and presents it to a host-side reader through a show-ahead read port. Overflow is flagged with a sticky error. The block decouples the receiver's one-byte output register from a consumer that may service bytes in bursts.

## Interface
- `DEPTH`, default 16: number of byte entries; must be a power of two and at least 2.
- `AFULL_LEVEL`, default 12: fill count at which `almost_full` asserts. Used only when the macro is defined; must satisfy 1 ≤ AFULL_LEVEL ≤ DEPTH.
- `clk_rx`, input, 1 bit: the single clock; the block uses only its rising edge.
- `reset_n`, input, 1 bit: asynchronous, active-low reset.
- `rx_byte`, input, 8 bits: byte from the receiver; valid whenever `rx_data_ready` is high.
- `rx_data_ready`, input, 1 bit: receiver's ready level. It may stay high for many cycles per byte.
- `rd_en`, input, 1 bit: pop request from the consumer.
- `rd_data`, output, 8 bits: head entry (show-ahead); valid while `rd_valid` = 1.
- `rd_valid`, output, 1 bit: FIFO not empty.
- `count`, output, $clog2(DEPTH)+1 bits: current number of stored bytes, range 0..DEPTH.
- `overrun`, output, 1 bit: sticky flag meaning a byte was dropped because the FIFO was full.
- `overrun_clr`, input, 1 bit: clears `overrun`; takes effect on the next clock edge.
- `almost_full`, output, 1 bit: present only with `UART_RX_FIFO_AFULL_EN`.

## Operation
- **Push detection.**
  - A register `rdy_q` holds `rx_data_ready` from the previous cycle.
  - A push event occurs in any cycle where `rx_data_ready` = 1 and `rdy_q` = 0, i.e. on the rising edge only.
  - A level held high never pushes twice.
- **Pop.** A pop occurs when `rd_en` = 1 and `rd_valid` = 1. `rd_en` while the FIFO is empty is ignored and has no side effects.
- **Fill states.** The fill state is derived from `count`:
  - EMPTY when `count` = 0.
  - PARTIAL when 0 < `count` < DEPTH.
  - FULL when `count` = DEPTH.
- **Transitions.**
  - Push alone: `count` increases by 1; EMPTY→PARTIAL, or PARTIAL→FULL when `count` reaches DEPTH.
  - Pop alone: `count` decreases by 1; the reverse transitions apply.
  - Push and pop in the same cycle: `count` is unchanged, and both operations are performed.
- **Push while FULL.**
  - Without a simultaneous pop: the byte is discarded, the memory and pointers are unchanged, and `overrun` is set.
  - With a simultaneous pop: the push is accepted and there is no overrun.
- **Pointers.** Write and read pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 naturally. FULL and EMPTY are decided by `count`, never by pointer equality alone.
- **Overrun flag.** If `overrun_clr` and a new overrun occur in the same cycle, set wins.
- **Reset (`reset_n` low, asynchronous).**
  - Pointers = 0, `count` = 0, `rd_valid` = 0, `overrun` = 0, `almost_full` = 0.
  - `rdy_q` = 1, so a ready level present at reset release is not taken as a new byte.
  - `rd_data` is don't-care; memory contents are not reset.
- **Reset mid-operation.** All stored bytes are lost. The first push after release requires `rx_data_ready` to go low and then high again.

## Timing
- **Push latency.** For a push in cycle N, the byte is written at the end of cycle N. `rd_valid` and `count` update in cycle N+1. If the FIFO was empty, `rd_data` shows the byte in cycle N+1.
- **Pop latency.** For a pop in cycle N, `rd_data` advances to the next entry and `count` decrements in cycle N+1.
- **Throughput.** Sustained pop rate is one byte per cycle. Push rate is bounded by the receiver's frame rate.
- **Output registers.** All outputs are registered, except that `rd_data` is a read of memory at the registered read pointer.
- **Overrun timing.** `overrun` asserts in the cycle after the dropped push.

## Configuration
- Macro `UART_RX_FIFO_AFULL_EN`.
- **Defined:**
  - Port `almost_full` exists.
  - It is registered and equals (`count` ≥ AFULL_LEVEL), evaluated on the next-state count, so it changes in the same cycle as `count`.
- **Undefined:** the `almost_full` port, its logic and the `AFULL_LEVEL` check are absent. All other behaviour is identical.

## Structure
- **Shared package `uart_pkg`:**
  - `UART_DATA_W` = 8.
  - `UART_RX_FIFO_DEPTH_DEF` = 16.
  - A typedef for the byte (`uart_byte_t`).
  - The fill-state enum {EMPTY, PARTIAL, FULL}.
- **Sub-module `uart_rx_fifo_mem`:**
  - DEPTH×8 storage with a synchronous write port and an asynchronous read port.
  - It has no reset.
  - The top level holds the pointers, count, edge detector and flags.

## Test plan
- **Reset and first push.**
  - Stimulus: reset, then hold `rx_data_ready` low 3 cycles, then raise it with `rx_byte` = 0xA5 for 20 cycles.
  - Required: exactly one push; `count` = 1; `rd_valid` = 1 and `rd_data` = 0xA5 one cycle after the edge.
- **Ordering.**
  - Stimulus: push 0x01, 0x02, 0x03, then hold `rd_en` high.
  - Required: `rd_data` reads 0x01, 0x02, 0x03 in consecutive cycles; then `rd_valid` = 0 and `count` = 0.
- **Overflow.**
  - Stimulus: push DEPTH+1 bytes 0x00..0x10 with no reads.
  - Required: `count` = 16 and `overrun` = 1.
  - Required: drain returns 0x00..0x0F; 0x10 is lost.
  - Required: `overrun_clr` pulse → `overrun` = 0.
- **Simultaneous push and pop.**
  - Stimulus: with the FIFO full, push and pop in the same cycle.
  - Required: `count` stays 16 and `overrun` stays 0.
  - Required: when the 16 entries present after that cycle are drained, the new byte comes out last.
- **Wrap-around and empty read.**
  - Stimulus: 40 alternating push/pop pairs, then assert `rd_en` while empty.
  - Required: data stays correct across pointer wrap; the empty read leaves `count` = 0 and the pointers unchanged.
- **Almost-full (macro defined, AFULL_LEVEL = 12).**
  - Required: `almost_full` rises in the cycle `count` becomes 12 and falls when `count` returns to 11.
  - Required: reset mid-fill clears `almost_full`, `count` and `rd_valid` immediately.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, default FIFO depth, byte type and
// the FIFO fill-state encoding with a helper that derives it from a count.
package uart_pkg;

  localparam int UART_DATA_W            = 8;
  localparam int UART_RX_FIFO_DEPTH_DEF = 16;

  typedef logic [UART_DATA_W-1:0] uart_byte_t;

  typedef enum logic [1:0] {
    EMPTY,
    PARTIAL,
    FULL
  } fill_state_e;

  // Fill state is a pure function of the stored-byte count.
  function automatic fill_state_e fill_state_of(input int unsigned cnt,
                                                input int unsigned depth);
    if (cnt == 0)          return EMPTY;
    else if (cnt >= depth) return FULL;
    else                   return PARTIAL;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// DEPTH x 8 storage for the receive FIFO: synchronous write port,
// asynchronous read port so the top level can offer show-ahead data.
module uart_rx_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH_DEF
) (
  input  logic                     clk_rx,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  uart_byte_t               wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output uart_byte_t               rdata
);

  uart_byte_t mem_q [DEPTH];

  // Write the incoming byte at the end of the push cycle.
  // NOTE: the storage array has no reset; its contents are only meaningful
  // behind the count, and a reset would force flops instead of RAM.
  always_ff @(posedge clk_rx) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. Captures one byte per
// rising edge of rx_data_ready, offers the head entry show-ahead, and flags
// dropped bytes with a sticky overrun bit.
// Optional: define UART_RX_FIFO_AFULL_EN to add the registered almost_full
// output (count >= AFULL_LEVEL).
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = UART_RX_FIFO_DEPTH_DEF
`ifdef UART_RX_FIFO_AFULL_EN
  , parameter int AFULL_LEVEL = 12
`endif
) (
  input  logic                   clk_rx,
  input  logic                   reset_n,
  input  uart_byte_t             rx_byte,
  input  logic                   rx_data_ready,
  input  logic                   rd_en,
  output uart_byte_t             rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overrun,
  input  logic                   overrun_clr
`ifdef UART_RX_FIFO_AFULL_EN
  , output logic                 almost_full
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic              rdy_q;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              overrun_q, overrun_d;
  logic              push, pop, wr_en;
  fill_state_e       fill;

  // Edge-detect the ready level, resolve push/pop against the fill state
  // and compute next pointers, count and flags.
  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fill      = fill_state_of(32'(count_q), 32'(DEPTH));
    push      = rx_data_ready & ~rdy_q;
    pop       = rd_en & (fill != EMPTY);
    wr_en     = push & ((fill != FULL) | pop);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    overrun_d = overrun_q;

    if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);

    count_d = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    valid_d = (count_d != '0);

    // A new drop outranks a clear in the same cycle.
    if (push && (fill == FULL) && !pop) overrun_d = 1'b1;
    else if (overrun_clr)               overrun_d = 1'b0;
  end

  // Pointer, count, flag and edge-detector state.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_rx or negedge reset_n) begin
    if (!reset_n) begin
      rdy_q     <= 1'b1;   // a level already high at release is not a new byte
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rdy_q     <= rx_data_ready;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk_rx (clk_rx),
    .we     (wr_en),
    .waddr  (wr_ptr_q),
    .wdata  (rx_byte),
    .raddr  (rd_ptr_q),
    .rdata  (rd_data)
  );

  assign rd_valid = valid_q;
  assign count    = count_q;
  assign overrun  = overrun_q;

`ifdef UART_RX_FIFO_AFULL_EN
  if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
    $error("uart_rx_fifo: AFULL_LEVEL out of range 1..DEPTH");
  end

  logic af_q;

  // Threshold on the next-state count so the flag moves with count.
  always_ff @(posedge clk_rx or negedge reset_n) begin
    if (!reset_n) af_q <= 1'b0;
    else          af_q <= (count_d >= CNT_W'(AFULL_LEVEL));
  end

  assign almost_full = af_q;
`endif

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: a queue scoreboard tracks the
// expected contents, a vector table covers single-cycle push/pop cases and
// hand-written sequences cover reset, ordering, overflow, wrap and
// (with UART_RX_FIFO_AFULL_EN) almost_full.
module tb_uart_rx_fifo;

  localparam int DEPTH = 16;
  localparam int AFULL = 12;

  logic       clk_rx = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] rx_byte = '0;
  logic       rx_data_ready = 1'b0;
  logic       rd_en = 1'b0;
  logic       overrun_clr = 1'b0;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [4:0] count;
  logic       overrun;
`ifdef UART_RX_FIFO_AFULL_EN
  logic       almost_full;
`endif

  uart_rx_fifo #(
    .DEPTH(DEPTH)
`ifdef UART_RX_FIFO_AFULL_EN
    , .AFULL_LEVEL(AFULL)
`endif
  ) dut (
    .clk_rx        (clk_rx),
    .reset_n       (reset_n),
    .rx_byte       (rx_byte),
    .rx_data_ready (rx_data_ready),
    .rd_en         (rd_en),
    .rd_data       (rd_data),
    .rd_valid      (rd_valid),
    .count         (count),
    .overrun       (overrun),
    .overrun_clr   (overrun_clr)
`ifdef UART_RX_FIFO_AFULL_EN
    , .almost_full (almost_full)
`endif
  );

  always #5 clk_rx = ~clk_rx;

  int         vectors = 0;
  int         miscompares = 0;
  logic [7:0] sb[$];
  bit         m_rdy = 1'b1;
  bit         m_ovr = 1'b0;

  typedef struct {
    bit         rdy;
    logic [7:0] b;
    bit         rd;
    int         exp_count;
    bit         exp_valid;
    logic [7:0] exp_data;
  } vec_t;

  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare every visible output against the scoreboard model.
  task automatic expect_state();
    check("count", 32'(count), 32'(sb.size()));
    check("rd_valid", 32'(rd_valid), 32'(sb.size() != 0));
    check("overrun", 32'(overrun), 32'(m_ovr));
    if (sb.size() != 0) check("head_data", 32'(rd_data), 32'(sb[0]));
`ifdef UART_RX_FIFO_AFULL_EN
    check("almost_full", 32'(almost_full), 32'(sb.size() >= AFULL));
`endif
  endtask

  // One clock cycle; entered and left 1 time unit after a rising edge.
  task automatic cycle(input bit rdy, input logic [7:0] b, input bit rd,
                       input bit clr);
    bit push, pop, full;
    logic [7:0] exp;
    rx_data_ready = rdy;
    rx_byte       = b;
    rd_en         = rd;
    overrun_clr   = clr;
    push = rdy && !m_rdy;
    pop  = rd && (sb.size() != 0);
    full = (sb.size() == DEPTH);
    @(negedge clk_rx);
    if (pop) begin
      exp = sb.pop_front();
      check("pop_data", 32'(rd_data), 32'(exp));
    end
    @(posedge clk_rx);
    #1;
    m_rdy = rdy;
    if (push && (!full || pop)) sb.push_back(b);
    if (clr) m_ovr = 1'b0;
    if (push && full && !pop) m_ovr = 1'b1;
    expect_state();
  endtask

  task automatic push_byte(input logic [7:0] b);
    cycle(1'b1, b, 1'b0, 1'b0);
    cycle(1'b0, b, 1'b0, 1'b0);
  endtask

  // Asynchronous reset pulse with rx_data_ready held at rdy throughout.
  task automatic do_reset(input bit rdy);
    rx_data_ready = rdy;
    rd_en         = 1'b0;
    overrun_clr   = 1'b0;
    reset_n       = 1'b0;
    #2;
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
`ifdef UART_RX_FIFO_AFULL_EN
    check("rst_almost_full", 32'(almost_full), 32'd0);
`endif
    sb.delete();
    m_ovr = 1'b0;
    @(negedge clk_rx);
    reset_n = 1'b1;
    @(posedge clk_rx);
    #1;
    m_rdy = rdy;
    expect_state();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b0, 8'h00, 1'b0, 0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'h11, 1'b0, 1, 1'b1, 8'h11};
    tbl[2] = '{1'b1, 8'h22, 1'b0, 1, 1'b1, 8'h11};
    tbl[3] = '{1'b0, 8'h00, 1'b0, 1, 1'b1, 8'h11};
    tbl[4] = '{1'b1, 8'h33, 1'b1, 1, 1'b1, 8'h33};
    tbl[5] = '{1'b1, 8'h44, 1'b1, 0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};
    tbl[7] = '{1'b1, 8'h55, 1'b0, 1, 1'b1, 8'h55};
    tbl[8] = '{1'b0, 8'h00, 1'b1, 0, 1'b0, 8'h00};

    @(posedge clk_rx);
    #1;

    // Ready held high across reset release must not push.
    do_reset(1'b1);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("no_push_at_release", 32'(count), 32'd0);

    // Reset and first push: low 3 cycles, then high 20 cycles with 0xA5.
    for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("first_push_count", 32'(count), 32'd1);
    check("first_push_valid", 32'(rd_valid), 32'd1);
    check("first_push_data", 32'(rd_data), 32'hA5);
    for (int i = 0; i < 19; i++) cycle(1'b1, 8'hA5, 1'b0, 1'b0);
    check("held_level_count", 32'(count), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // Table-driven single-cycle push/pop/held-level cases.
    for (int i = 0; i < 9; i++) begin
      cycle(tbl[i].rdy, tbl[i].b, tbl[i].rd, 1'b0);
      check("tbl_count", 32'(count), 32'(tbl[i].exp_count));
      check("tbl_valid", 32'(rd_valid), 32'(tbl[i].exp_valid));
      if (tbl[i].exp_valid) check("tbl_data", 32'(rd_data), 32'(tbl[i].exp_data));
    end

    // Ordering: push 01,02,03 then hold rd_en.
    push_byte(8'h01);
    push_byte(8'h02);
    push_byte(8'h03);
    for (int i = 0; i < 4; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("order_empty_valid", 32'(rd_valid), 32'd0);
    check("order_empty_count", 32'(count), 32'd0);

    // Overflow: DEPTH+1 bytes, 0x10 dropped.
    for (int i = 0; i <= DEPTH; i++) push_byte(8'(i));
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_flag", 32'(overrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("ovf_clear", 32'(overrun), 32'd0);

    // Full: simultaneous push and pop is accepted without overrun.
    cycle(1'b1, 8'h77, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);
    check("pushpop_full_count", 32'(count), 32'd16);
    check("pushpop_full_ovr", 32'(overrun), 32'd0);

    // Drop and clear in the same cycle: set wins.
    cycle(1'b1, 8'h99, 1'b0, 1'b1);
    check("set_wins", 32'(overrun), 32'd1);
    cycle(1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_after_set", 32'(overrun), 32'd0);

    // Drain: 0x01..0x0F then 0x77 last.
    for (int i = 0; i < DEPTH - 1; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("last_is_new_byte", 32'(rd_data), 32'h77);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("drained_count", 32'(count), 32'd0);

    // Wrap-around: 40 push/pop pairs, then empty reads.
    for (int i = 0; i < 40; i++) begin
      cycle(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      cycle(1'b0, 8'h00, 1'b1, 1'b0);
    end
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("empty_read_count", 32'(count), 32'd0);
    push_byte(8'hC3);
    check("after_empty_read_data", 32'(rd_data), 32'hC3);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

`ifdef UART_RX_FIFO_AFULL_EN
    // almost_full rises with count 12, falls at 11, cleared by reset.
    for (int i = 0; i < AFULL - 1; i++) push_byte(8'(8'hB0 + i));
    check("af_below", 32'(almost_full), 32'd0);
    cycle(1'b1, 8'hBF, 1'b0, 1'b0);
    check("af_rise_count", 32'(count), 32'd12);
    check("af_rise", 32'(almost_full), 32'd1);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    check("af_fall", 32'(almost_full), 32'd0);
    push_byte(8'hE1);
    push_byte(8'hE2);
    check("af_high_again", 32'(almost_full), 32'd1);
    do_reset(1'b0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
